// File: rtl/fp_collector_pkg.sv
// Shared state encoding and per-slot special-value flag indices for the FP operand collector.
package fp_collector_pkg;

    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        LOAD      = 3'd1,
        ACCEPT    = 3'd2,
        WAIT_DONE = 3'd3,
        START     = 3'd4
    } state_t;

    localparam int ZERO   = 0;
    localparam int INF    = 1;
    localparam int NAN    = 2;
    localparam int FLAG_W = 3;

endpackage

// File: rtl/fp_operand_bank.sv
// NUM_OPS operand registers with a slot-select write port; per-slot {nan,inf,zero}
// classification is built only when FP_SPECIAL_DETECT_EN is defined.
module fp_operand_bank
    import fp_collector_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 2,
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int SEL_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [SEL_W-1:0]            sel,
    input  logic [WIDTH-1:0]            wdata,
    output logic [NUM_OPS*WIDTH-1:0]    op_bus,
    output logic [FLAG_W*NUM_OPS-1:0]   spec_flags
);

    if (NUM_OPS < 1 || EXP_W < 1 || MAN_W < 1) begin : g_bad_cfg
        $error("fp_operand_bank: NUM_OPS, EXP_W and MAN_W must all be at least 1");
    end

    logic [NUM_OPS-1:0][WIDTH-1:0] slots;

    always_ff @(posedge clk) begin
        if (rst) begin
            slots <= '0;
        end else if (we) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (SEL_W'(k) == sel) slots[k] <= wdata;
            end
        end
    end

    assign op_bus = slots;

`ifdef FP_SPECIAL_DETECT_EN
    if (WIDTH != 1 + EXP_W + MAN_W) begin : g_bad_fields
        $error("fp_operand_bank: WIDTH must equal 1+EXP_W+MAN_W");
    end

    logic [EXP_W-1:0]                w_exp;
    logic [MAN_W-1:0]                w_man;
    logic [FLAG_W-1:0]               w_flags;
    logic [NUM_OPS-1:0][FLAG_W-1:0]  flags;

    assign w_exp = wdata[WIDTH-2 -: EXP_W];
    assign w_man = wdata[MAN_W-1:0];

    always_comb begin
        w_flags       = '0;
        w_flags[ZERO] = (w_exp == '0) && (w_man == '0);
        w_flags[INF]  = (w_exp == '1) && (w_man == '0);
        w_flags[NAN]  = (w_exp == '1) && (w_man != '0);
    end

    // Flags are captured with the data so they always describe the slot contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (we) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (SEL_W'(k) == sel) flags[k] <= w_flags;
            end
        end
    end

    assign spec_flags = flags;
`else
    assign spec_flags = '0;
`endif

endmodule

// File: rtl/fp_operand_collector.sv
// Serially collects NUM_OPS operands over a four-phase handshake, then starts the FP core
// once it reports idle. Optional special-value flags: define FP_SPECIAL_DETECT_EN.
module fp_operand_collector
    import fp_collector_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 2,
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inReady,
    input  logic [WIDTH-1:0]              inBus,
    input  logic                          doneFP,
    output logic                          inAccept,
    output logic                          startFP,
    output logic [NUM_OPS*WIDTH-1:0]      opBus,
    output logic [$clog2(NUM_OPS+1)-1:0]  opCount,
    output logic                          busy,
    output logic [FLAG_W*NUM_OPS-1:0]     specFlags,
    output state_t                        state_dbg
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS);

    state_t           state;
    logic [CNT_W-1:0] idx;

    assign opCount   = idx;
    assign state_dbg = state;

    // Handshake: upstream raises inReady with inBus valid and holds both until inAccept;
    // it then drops inReady, and inAccept falls after that. One load per inReady assertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            idx      <= '0;
            inAccept <= 1'b0;
            startFP  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (inReady) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= ACCEPT;
                    idx      <= idx + CNT_W'(1);
                    inAccept <= 1'b1;
                end
                ACCEPT: begin
                    if (!inReady) begin
                        inAccept <= 1'b0;
                        state    <= (idx == LAST) ? WAIT_DONE : COLLECT;
                    end
                end
                WAIT_DONE: begin
                    if (doneFP) begin
                        state   <= START;
                        startFP <= 1'b1;
                    end
                end
                START: begin
                    state   <= COLLECT;
                    startFP <= 1'b0;
                    idx     <= '0;
                    busy    <= 1'b0;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // The write lands on the edge leaving LOAD, so slots never change around startFP.
    fp_operand_bank #(
        .WIDTH   (WIDTH),
        .NUM_OPS (NUM_OPS),
        .EXP_W   (EXP_W),
        .MAN_W   (MAN_W),
        .SEL_W   (CNT_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .we         (state == LOAD),
        .sel        (idx),
        .wdata      (inBus),
        .op_bus     (opBus),
        .spec_flags (specFlags)
    );

endmodule

// File: doc/fp_operand_collector.md
Name: fp_operand_collector

Overview:
- Parametrised successor to the two-operand FP input wrapper.
- Collects NUM_OPS operands of WIDTH bits serially from one input bus, using the existing four-phase inReady/inAccept handshake.
- Holds the operands stable on a packed output bus, waits for the FP core to report idle (doneFP), then pulses startFP.
- Sits between the upstream host/testbench bus and any multi-operand FP datapath (multiplier, FMA, accumulator).

Parameters:
- WIDTH, 32, operand width in bits.
- NUM_OPS, 2, number of operands per operation; must be at least 1.
- EXP_W, 8, exponent field width; used only by the optional feature.
- MAN_W, 23, mantissa field width; used only by the optional feature. With the feature enabled, WIDTH must equal 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inReady  in  1  upstream asserts while inBus holds a valid operand; held until inAccept is seen.
- inBus  in  WIDTH  operand data.
- doneFP  in  1  level signal; FP core idle/result valid.
- inAccept  out  1  handshake acknowledge.
- startFP  out  1  one-cycle start pulse to the FP core.
- opBus  out  NUM_OPS*WIDTH  operand slot k occupies bits [k*WIDTH +: WIDTH].
- opCount  out  $clog2(NUM_OPS+1)  number of operands loaded in the current set.
- busy  out  1  high unless in COLLECT with opCount==0.
- specFlags  out  3*NUM_OPS  per-slot {nan,inf,zero}; driven only when the optional feature is enabled.

Behaviour:
- Reset: one clock and a synchronous, active-high reset; rst is sampled only on a clk rising edge.
  - All slot registers, index and flags go to 0; state goes to COLLECT.
  - inAccept=0, startFP=0, opCount=0, busy=0.
  - Reset mid-operation discards the partial or complete set; no startFP is emitted.
- State machine, Moore outputs:
  - COLLECT: if inReady, go to LOAD; otherwise stay.
  - LOAD (exactly 1 cycle): write inBus into slot idx, idx<=idx+1, go to ACCEPT. inAccept=0.
  - ACCEPT: inAccept=1. Stay while inReady=1. When inReady=0, go to WAIT_DONE if idx==NUM_OPS, else COLLECT.
  - WAIT_DONE: if doneFP, go to START; otherwise stay. No operand is accepted in this state.
  - START (1 cycle): startFP=1, idx<=0, go to COLLECT.
- Handshake is four-phase:
  - One LOAD per inReady assertion.
  - inReady held high during ACCEPT never causes a second load.
  - inReady high during WAIT_DONE or START is ignored until COLLECT.
- Operand stability:
  - Only LOAD writes a slot, and it writes only slot idx.
  - opBus is stable from the last LOAD until at least 2 cycles after startFP, so the FP core may sample it in the startFP cycle or the next one.
- Latency:
  - From inReady high sampled in COLLECT, inAccept rises 2 cycles later.
  - From the last inReady low sampled in ACCEPT, with doneFP already high, startFP asserts in the 2nd following cycle.
- doneFP already high on entering WAIT_DONE: no extra wait.
- doneFP low: wait indefinitely; reset is the only exit.
- NUM_OPS==1: every accepted operand leads to WAIT_DONE.
- opCount equals idx. It reaches NUM_OPS in ACCEPT of the last operand and returns to 0 in the cycle after START.

Optional Feature:
- Macro: FP_SPECIAL_DETECT_EN.
- With the macro defined:
  - On each LOAD, the slot's flags are registered alongside the data, from inBus.
  - zero: exponent==0 and mantissa==0.
  - inf: exponent all-ones and mantissa==0.
  - nan: exponent all-ones and mantissa!=0.
  - Flags are cleared on reset and hold until that slot is rewritten.
- Without the macro: specFlags is tied to 0 and no classifier logic is generated.

Decomposition:
- Package fp_collector_pkg:
  - State encoding constants: COLLECT, LOAD, ACCEPT, WAIT_DONE, START.
  - Flag bit indices: ZERO=0, INF=1, NAN=2.
- Natural sub-module fp_operand_bank:
  - NUM_OPS enabled WIDTH-bit registers with synchronous reset.
  - Slot-select write port.
  - Optional per-slot classifier.
- The top level holds the FSM and the index counter.

Test Plan:
- Load 0x3FC00000 then 0x40000000 with NUM_OPS=2 and doneFP=1 -> opBus={0x40000000,0x3FC00000}; single-cycle startFP; opCount returns 0.
- inReady held high for 10 cycles in ACCEPT -> exactly one LOAD; inAccept high until inReady drops; opCount=1.
- doneFP=0 for 20 cycles after the set completes -> stays in WAIT_DONE and no startFP. doneFP=1 -> startFP exactly 1 cycle later, once.
- rst pulsed after the first of 3 operands (NUM_OPS=3) -> opBus=0, opCount=0, no startFP. A fresh 3-operand set then completes normally.
- inReady asserted during WAIT_DONE and START -> ignored; the operand loads in slot 0 only after COLLECT. The previous set stays unchanged through the startFP cycle.
- FP_SPECIAL_DETECT_EN defined, operands 0x00000000, 0x7F800000, 0x7FC00000 (NUM_OPS=3) -> specFlags slots={zero},{inf},{nan}. Without the macro -> specFlags==0.
